shift_chain_tx: RTL and testbench

- Parametrised write-only driver for daisy-chained serial-in/parallel-out shift-register ICs, e.g. several CD4094BE.
- Generalises the single 8-bit register driver in three ways:
  - frame width is any length from 2 to 256 bits;
  - bit order is selectable;
  - strobe pulse length is programmable.
- Uses a valid/ready input handshake, a done pulse, and optional serial readback from the end of the chain.
- Runs on the system clock. Output timing is paced by an external clock-enable `tick`, so the slow ICs can keep up.

---
 rtl/shift_chain_tx.sv | 162 ++++++++++++++++
 tb/tb_shift_chain_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_chain_tx.sv
// shift_chain_tx: write-only driver for a daisy chain of serial-in/parallel-out
// shift registers (e.g. CD4094). A frame is shifted out one phase per tick and
// then latched with a strobe pulse held for STROBE_TICKS tick periods.
// Optional serial readback of the chain tail: define SHIFT_CHAIN_READBACK_EN.
module shift_chain_tx #(
    parameter int WIDTH        = 16,
    parameter bit MSB_FIRST    = 1'b1,
    parameter int STROBE_TICKS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
`ifdef SHIFT_CHAIN_READBACK_EN
    input  logic             sr_q,
    output logic [WIDTH-1:0] rx_data,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             sr_data,
    output logic             sr_clk,
    output logic             sr_strobe
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]    STB_LAST = 4'(STROBE_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_STROBE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_bit, w_bit_nxt;
    logic [3:0]       r_stb, w_stb_nxt;
    logic [WIDTH-1:0] r_shreg, w_shreg_nxt, w_shreg_sh;
    logic             r_data, w_data_nxt;
    logic             r_clk, w_clk_nxt;
    logic             r_strobe, w_strobe_nxt;
    logic             r_done, w_done_nxt;
    logic             r_ready, r_busy;

    // Rotate rather than shift so the outgoing bit stays in the register;
    // the next bit to send always sits at the output end.
    assign w_shreg_sh = MSB_FIRST ? {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]}
                                  : {r_shreg[0], r_shreg[WIDTH-1:1]};

    // Next-state and next-output logic; data only moves with the falling sr_clk.
    always_comb begin
        w_state_nxt  = r_state;
        w_bit_nxt    = r_bit;
        w_stb_nxt    = r_stb;
        w_shreg_nxt  = r_shreg;
        w_data_nxt   = r_data;
        w_clk_nxt    = r_clk;
        w_strobe_nxt = r_strobe;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wr_valid) begin
                    w_shreg_nxt = wr_data;
                    w_bit_nxt   = '0;
                    w_data_nxt  = MSB_FIRST ? wr_data[WIDTH-1] : wr_data[0];
                    w_clk_nxt   = 1'b0;
                    w_state_nxt = S_LOW;
                end
            end
            S_LOW: begin
                if (tick) begin
                    w_clk_nxt   = 1'b1;
                    w_state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (tick) begin
                    w_clk_nxt = 1'b0;
                    if (r_bit == BIT_LAST) begin
                        w_strobe_nxt = 1'b1;
                        w_stb_nxt    = '0;
                        w_state_nxt  = S_STROBE;
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shreg_nxt = w_shreg_sh;
                        w_data_nxt  = MSB_FIRST ? w_shreg_sh[WIDTH-1] : w_shreg_sh[0];
                        w_state_nxt = S_LOW;
                    end
                end
            end
            S_STROBE: begin
                if (tick) begin
                    if (r_stb == STB_LAST) begin
                        w_strobe_nxt = 1'b0;
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_stb_nxt = r_stb + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts a frame without strobing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_bit    <= '0;
            r_stb    <= '0;
            r_shreg  <= '0;
            r_data   <= 1'b0;
            r_clk    <= 1'b0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bit    <= w_bit_nxt;
            r_stb    <= w_stb_nxt;
            r_shreg  <= w_shreg_nxt;
            r_data   <= w_data_nxt;
            r_clk    <= w_clk_nxt;
            r_strobe <= w_strobe_nxt;
            r_done   <= w_done_nxt;
            r_ready  <= (w_state_nxt == S_IDLE);
            r_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    assign ready     = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sr_data   = r_data;
    assign sr_clk    = r_clk;
    assign sr_strobe = r_strobe;

`ifdef SHIFT_CHAIN_READBACK_EN
    logic             w_sample;
    logic [WIDTH-1:0] r_rx_sh, r_rx;

    // The chain tail is sampled on the tick that drops sr_clk.
    assign w_sample = (r_state == S_HIGH) && tick;

    // Sample k lands where transmit bit k came from; publish on done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sh <= '0;
            r_rx    <= '0;
        end else begin
            if (w_sample)
                r_rx_sh <= MSB_FIRST ? {r_rx_sh[WIDTH-2:0], sr_q}
                                     : {sr_q, r_rx_sh[WIDTH-1:1]};
            if (w_done_nxt)
                r_rx <= r_rx_sh;
        end
    end

    assign rx_data = r_rx;
`endif

endmodule

// File: tb/tb_shift_chain_tx.sv
// Bench for shift_chain_tx: three instances (16/MSB/1, 16/LSB/1, 8/MSB/3)
// checked every cycle against a tick-count model, plus directed frame checks.
module tb_shift_chain_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        t01 = 1'b0;
    logic [2:0]  tick;
    logic [2:0]  wv = 3'b000;
    logic [15:0] wd [3];
    logic [2:0]  rdy, bsy, dn, sdat, sclk, sstb;

    assign tick = {1'b1, t01, t01};

`ifdef SHIFT_CHAIN_READBACK_EN
    logic        sr_q0 = 1'b1;
    logic [15:0] rx0, rx1;
    logic [7:0]  rx2;
    logic [15:0] ch = 16'h0, chout = 16'h0;
    logic        qn = 1'b1, pc = 1'b0, ch_pre = 1'b0;
`endif

    shift_chain_tx #(.WIDTH(16), .MSB_FIRST(1'b1), .STROBE_TICKS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .tick(tick[0]), .wr_valid(wv[0]), .wr_data(wd[0]),
`ifdef SHIFT_CHAIN_READBACK_EN
        .sr_q(sr_q0), .rx_data(rx0),
`endif
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]),
        .sr_data(sdat[0]), .sr_clk(sclk[0]), .sr_strobe(sstb[0]));

    shift_chain_tx #(.WIDTH(16), .MSB_FIRST(1'b0), .STROBE_TICKS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .tick(tick[1]), .wr_valid(wv[1]), .wr_data(wd[1]),
`ifdef SHIFT_CHAIN_READBACK_EN
        .sr_q(1'b0), .rx_data(rx1),
`endif
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]),
        .sr_data(sdat[1]), .sr_clk(sclk[1]), .sr_strobe(sstb[1]));

    shift_chain_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .STROBE_TICKS(3)) u2 (
        .clk(clk), .rst_n(rst_n), .tick(tick[2]), .wr_valid(wv[2]), .wr_data(wd[2][7:0]),
`ifdef SHIFT_CHAIN_READBACK_EN
        .sr_q(1'b0), .rx_data(rx2),
`endif
        .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]),
        .sr_data(sdat[2]), .sr_clk(sclk[2]), .sr_strobe(sstb[2]));

    function automatic int fw(int i); return (i == 2) ? 8 : 16; endfunction
    function automatic bit fm(int i); return (i == 1) ? 1'b0 : 1'b1; endfunction
    function automatic int fs(int i); return (i == 2) ? 3 : 1; endfunction

    // tick for instances 0/1: one pulse every 4 clk cycles
    int tcnt = 0;
    initial forever begin
        @(negedge clk);
        tcnt++;
        t01 = (tcnt % 4 == 0);
    end

    int mpass = 0, mtot = 0, spass = 0, stot = 0;

    task automatic chkm(string n, int i, logic [31:0] a, logic [31:0] e);
        mtot++;
        if (a === e) mpass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h", n, i, a, e);
    endtask

    task automatic chks(string n, logic [31:0] a, logic [31:0] e);
        stot++;
        if (a === e) spass++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    // model state: phase count since accept
    bit          act [3];
    int          p [3];
    logic [15:0] val [3];
    logic        lastd [3];
    // measurements of DUT behaviour per frame
    bit          mrun [3];
    int          mtick [3], mcyc [3], mrise [3], mstb [3], mbad [3];
    logic [15:0] mcap [3];
    int          d_tick [3], d_cyc [3], d_rise [3], d_stb [3], d_bad [3];
    logic [15:0] d_cap [3];
    int          ndone [3], acc_cyc [3], done_cyc [3];
    logic        psclk [3];
    int          gcyc = 0;

    // Model update from inputs seen at the edge, then compare 1 unit later.
    always @(posedge clk) begin
        logic       rs;
        logic [2:0] st, sw;
        logic [15:0] sd [3];
        bit         acc, de;
        int         k, w;
        rs = rst_n; st = tick; sw = wv;
        for (int i = 0; i < 3; i++) sd[i] = wd[i];
        #1;
        gcyc++;
        for (int i = 0; i < 3; i++) begin
            w = fw(i); acc = 1'b0; de = 1'b0;
            if (!rs) begin
                act[i] = 1'b0; p[i] = 0; lastd[i] = 1'b0; mrun[i] = 1'b0;
            end else if (!act[i]) begin
                if (sw[i]) begin
                    act[i] = 1'b1; p[i] = 0; val[i] = sd[i]; acc = 1'b1;
                end
            end else if (st[i]) begin
                p[i]++;
                if (p[i] == 2 * w + fs(i)) begin act[i] = 1'b0; de = 1'b1; end
            end
            if (act[i]) begin
                k = (p[i] / 2 < w - 1) ? p[i] / 2 : w - 1;
                lastd[i] = fm(i) ? val[i][w-1-k] : val[i][k];
            end
            chkm("sr_clk",    i, 32'(sclk[i]), 32'(act[i] && p[i] < 2 * w && p[i] % 2 == 1));
            chkm("sr_strobe", i, 32'(sstb[i]), 32'(act[i] && p[i] >= 2 * w));
            chkm("sr_data",   i, 32'(sdat[i]), 32'(lastd[i]));
            chkm("ready",     i, 32'(rdy[i]),  32'(!act[i]));
            chkm("busy",      i, 32'(bsy[i]),  32'(act[i]));
            chkm("done",      i, 32'(dn[i]),   32'(de));

            if (acc) begin
                mrun[i] = 1'b1; mtick[i] = 0; mcyc[i] = 0; mrise[i] = 0;
                mstb[i] = 0; mbad[i] = 0; mcap[i] = '0; acc_cyc[i] = gcyc;
            end else if (mrun[i]) begin
                mcyc[i]++;
                if (st[i]) mtick[i]++;
            end
            if (mrun[i]) begin
                if (sclk[i] && !psclk[i]) begin
                    mrise[i]++; mcap[i] = {mcap[i][14:0], sdat[i]};
                end
                if (sstb[i]) begin mstb[i]++; if (sclk[i]) mbad[i]++; end
                if (dn[i]) begin
                    mrun[i] = 1'b0; d_tick[i] = mtick[i]; d_cyc[i] = mcyc[i];
                    d_rise[i] = mrise[i]; d_stb[i] = mstb[i]; d_bad[i] = mbad[i];
                    d_cap[i] = mcap[i]; ndone[i]++; done_cyc[i] = gcyc;
                end
            end
            psclk[i] = sclk[i];
        end
`ifdef SHIFT_CHAIN_READBACK_EN
        // 4094 chain: shifts on rising sr_clk, serial out updates on falling edge
        if (ch_pre) begin
            ch = 16'hBEEF; qn = 1'b1;
        end else begin
            if (sclk[0] && !pc) ch = {ch[14:0], sdat[0]};
            if (!sclk[0] && pc) qn = ch[15];
            if (sstb[0]) chout = ch;
        end
        pc = sclk[0];
        sr_q0 = qn;
`endif
    end

    task automatic wait_done(int i, int n0, int bound);
        int c = 0;
        while (ndone[i] == n0 && c < bound) begin @(negedge clk); c++; end
        chks("done_timeout", 32'(ndone[i] != n0), 32'd1);
    endtask

    task automatic send(int i, logic [15:0] d);
        int n0;
        n0 = ndone[i];
        @(negedge clk); wd[i] = d; wv[i] = 1'b1;
        @(negedge clk); wv[i] = 1'b0;
        wait_done(i, n0, 400);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, c, dc;
        for (int i = 0; i < 3; i++) wd[i] = '0;
        repeat (3) @(negedge clk);
        chks("rst_ready", 32'(rdy), 32'h7);
        chks("rst_outs", 32'({sdat, sclk, sstb, dn, bsy}), 32'h0);
        rst_n = 1'b1;

        // MSB-first 16-bit frame, tick every 4 cycles
        send(0, 16'hA5C3);
        chks("a5c3_bits",   32'(d_cap[0]), 32'hA5C3);
        chks("a5c3_rises",  d_rise[0], 16);
        chks("a5c3_strobe", d_stb[0], 4);
        chks("a5c3_stbclk", d_bad[0], 0);
        chks("a5c3_ticks",  d_tick[0], 33);

        // LSB-first
        send(1, 16'h0001);
        chks("lsb_bits",  32'(d_cap[1]), 32'h8000);
        chks("lsb_rises", d_rise[1], 16);
        chks("lsb_ticks", d_tick[1], 33);

        // 8-bit, strobe 3 ticks, tick held high
        send(2, 16'h00FF);
        chks("w8_bits",   32'(d_cap[2]), 32'h00FF);
        chks("w8_rises",  d_rise[2], 8);
        chks("w8_strobe", d_stb[2], 3);
        chks("w8_cycles", d_cyc[2], 19);

        // back-to-back with wr_valid held
        n0 = ndone[2];
        @(negedge clk); wd[2] = 16'h00A5; wv[2] = 1'b1;
        wait_done(2, n0, 100);
        dc = done_cyc[2];
        wait_done(2, n0 + 1, 100);
        wv[2] = 1'b0;
        chks("b2b_gap",  acc_cyc[2] - dc, 1);
        chks("b2b_bits", 32'(d_cap[2]), 32'h00A5);

        // write attempt mid-frame is ignored
        n0 = ndone[0];
        @(negedge clk); wd[0] = 16'h5A3C; wv[0] = 1'b1;
        @(negedge clk); wv[0] = 1'b0;
        repeat (20) @(negedge clk);
        chks("mid_ready", 32'(rdy[0]), 32'h0);
        wd[0] = 16'h1234; wv[0] = 1'b1;
        repeat (8) @(negedge clk);
        wv[0] = 1'b0;
        wait_done(0, n0, 400);
        chks("mid_bits", 32'(d_cap[0]), 32'h5A3C);

        // reset during HIGH of bit 5
        n0 = ndone[0];
        @(negedge clk); wd[0] = 16'hA5C3; wv[0] = 1'b1;
        @(negedge clk); wv[0] = 1'b0;
        c = 0;
        while (mrise[0] < 6 && c < 200) begin @(negedge clk); c++; end
        chks("rst_pre_clk", 32'({sclk[0], sdat[0]}), 32'h3);
        rst_n = 1'b0;
        #1;
        chks("rst_abort", 32'({sclk[0], sstb[0], sdat[0]}), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chks("rst_post_ready", 32'(rdy[0]), 32'h1);
        chks("rst_no_done", ndone[0], n0);
`ifdef SHIFT_CHAIN_READBACK_EN
        chks("rst_rx", 32'(rx0), 32'h0);
`endif
        send(0, 16'h00FF);
        chks("post_rst_bits",  32'(d_cap[0]), 32'h00FF);
        chks("post_rst_rises", d_rise[0], 16);

`ifdef SHIFT_CHAIN_READBACK_EN
        @(negedge clk); ch_pre = 1'b1;
        @(negedge clk); ch_pre = 1'b0;
        send(0, 16'h1111);
        chks("rb_rx",    32'(rx0), 32'hBEEF);
        chks("rb_chain", 32'(chout), 32'h1111);
        repeat (3) @(negedge clk);
        chks("rb_hold",  32'(rx0), 32'hBEEF);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", mpass + spass, mtot + stot);
        $finish;
    end

endmodule
